// File: rtl/button_bcd_counter.sv
// Four-digit BCD up/down counter driven by debounced up/down/clear buttons.
// One immediate step per press, then auto-repeat after c_REPEAT_DELAY cycles
// and every c_REPEAT_PERIOD cycles after that while the button is held.
module button_bcd_counter #(
    parameter int c_REPEAT_DELAY  = 50000000,
    parameter int c_REPEAT_PERIOD = 10000000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Up,
    input  logic        i_Down,
    input  logic        i_Clear,
    output logic [15:0] o_Bcd,
    output logic        o_Step
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD_UP = 3'd1,
        ST_RPT_UP  = 3'd2,
        ST_HOLD_DN = 3'd3,
        ST_RPT_DN  = 3'd4,
        ST_LOCK    = 3'd5
    } state_t;

    // Terminal timer values; the timer counts from 0 up to these inclusive.
    localparam logic [26:0] c_DELAY_LAST  = 27'(c_REPEAT_DELAY - 1);
    localparam logic [26:0] c_PERIOD_LAST = 27'(c_REPEAT_PERIOD - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [26:0] timer_r;
    logic [26:0] timer_nxt_s;
    logic        step_up_s;
    logic        step_dn_s;
    logic [15:0] bcd_r;
    logic [15:0] bcd_nxt_s;
    logic        step_r;
    logic        step_nxt_s;

    // Increment a packed 4-digit BCD value, carry rippling through all digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Decrement a packed 4-digit BCD value, borrow rippling through all digits.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // State and repeat-timer register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r <= ST_IDLE;
            timer_r <= 27'd0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Next-state, timer and step-request logic; opposite button beats a due step.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        step_up_s   = 1'b0;
        step_dn_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = 27'd0;
                if (i_Up && !i_Down) begin
                    step_up_s   = 1'b1;
                    state_nxt_s = ST_HOLD_UP;
                end else if (i_Down && !i_Up) begin
                    step_dn_s   = 1'b1;
                    state_nxt_s = ST_HOLD_DN;
                end else if (i_Up && i_Down) begin
                    state_nxt_s = ST_LOCK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD_UP, ST_RPT_UP: begin
                if (i_Down) begin
                    state_nxt_s = ST_LOCK;
                    timer_nxt_s = 27'd0;
                end else if (!i_Up) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = 27'd0;
                end else if (timer_r == ((state_r == ST_HOLD_UP) ? c_DELAY_LAST : c_PERIOD_LAST)) begin
                    step_up_s   = 1'b1;
                    state_nxt_s = ST_RPT_UP;
                    timer_nxt_s = 27'd0;
                end else begin
                    timer_nxt_s = timer_r + 27'd1;
                end
            end
            ST_HOLD_DN, ST_RPT_DN: begin
                if (i_Up) begin
                    state_nxt_s = ST_LOCK;
                    timer_nxt_s = 27'd0;
                end else if (!i_Down) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = 27'd0;
                end else if (timer_r == ((state_r == ST_HOLD_DN) ? c_DELAY_LAST : c_PERIOD_LAST)) begin
                    step_dn_s   = 1'b1;
                    state_nxt_s = ST_RPT_DN;
                    timer_nxt_s = 27'd0;
                end else begin
                    timer_nxt_s = timer_r + 27'd1;
                end
            end
            ST_LOCK: begin
                timer_nxt_s = 27'd0;
                if (!i_Up && !i_Down) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = 27'd0;
            end
        endcase
    end

    // Next count and step pulse; clear forces zero and swallows any step.
    always_comb begin
        bcd_nxt_s  = bcd_r;
        step_nxt_s = 1'b0;
        if (i_Clear) begin
            bcd_nxt_s  = 16'h0000;
            step_nxt_s = 1'b0;
        end else if (step_up_s) begin
            bcd_nxt_s  = bcd_inc(bcd_r);
            step_nxt_s = 1'b1;
        end else if (step_dn_s) begin
            bcd_nxt_s  = bcd_dec(bcd_r);
            step_nxt_s = 1'b1;
        end else begin
            bcd_nxt_s  = bcd_r;
            step_nxt_s = 1'b0;
        end
    end

    // Registered count and step outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            bcd_r  <= 16'h0000;
            step_r <= 1'b0;
        end else begin
            bcd_r  <= bcd_nxt_s;
            step_r <= step_nxt_s;
        end
    end

    assign o_Bcd  = bcd_r;
    assign o_Step = step_r;

endmodule

// File: tb/tb_button_bcd_counter.sv
// Directed bench for button_bcd_counter with c_REPEAT_DELAY=8, c_REPEAT_PERIOD=4.
module tb_button_bcd_counter;

    logic        i_Clk;
    logic        i_Reset;
    logic        i_Up;
    logic        i_Down;
    logic        i_Clear;
    logic [15:0] o_Bcd;
    logic        o_Step;

    int vectors;
    int errors;
    int exp_cnt;

    button_bcd_counter #(
        .c_REPEAT_DELAY (8),
        .c_REPEAT_PERIOD(4)
    ) dut (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .i_Up   (i_Up),
        .i_Down (i_Down),
        .i_Clear(i_Clear),
        .o_Bcd  (o_Bcd),
        .o_Step (o_Step)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Decimal integer to packed BCD, independent of the DUT's digit logic.
    function automatic logic [15:0] to_bcd(input int v);
        int t;
        logic [15:0] r;
        t = v;
        r[3:0]   = 4'(t % 10); t = t / 10;
        r[7:4]   = 4'(t % 10); t = t / 10;
        r[11:8]  = 4'(t % 10); t = t / 10;
        r[15:12] = 4'(t % 10);
        return r;
    endfunction

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Up = 1'b0; i_Down = 1'b0; i_Clear = 1'b0;
        tick(); tick();
        vectors++;
        if (o_Bcd !== 16'h0000 || o_Step !== 1'b0) begin
            $display("FAIL reset_value: bcd=%h step=%b, want bcd=0000 step=0", o_Bcd, o_Step);
            errors++;
        end
        i_Reset = 1'b0;
        tick();
        vectors++;
        if (o_Bcd !== 16'h0000 || o_Step !== 1'b0) begin
            $display("FAIL reset_release: bcd=%h step=%b, want bcd=0000 step=0", o_Bcd, o_Step);
            errors++;
        end
        exp_cnt = 0;
    endtask

    task automatic test_single_press();
        i_Up = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0001 || o_Step !== (c == 0)) begin
                $display("FAIL single_press c=%0d: bcd=%h step=%b, want bcd=0001 step=%b",
                         c, o_Bcd, o_Step, (c == 0));
                errors++;
            end
        end
        i_Up = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0001 || o_Step !== 1'b0) begin
                $display("FAIL single_release c=%0d: bcd=%h step=%b, want bcd=0001 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
        exp_cnt = 1;
    endtask

    task automatic test_hold_repeat();
        logic due;
        i_Clear = 1'b1;
        tick();
        vectors++;
        if (o_Bcd !== 16'h0000 || o_Step !== 1'b0) begin
            $display("FAIL clear_idle: bcd=%h step=%b, want bcd=0000 step=0", o_Bcd, o_Step);
            errors++;
        end
        i_Clear = 1'b0;
        tick();
        exp_cnt = 0;
        i_Up = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            due = (c == 0) || (c == 8) || (c > 8 && ((c - 8) % 4) == 0);
            if (due) exp_cnt++;
            vectors++;
            if (o_Bcd !== to_bcd(exp_cnt) || o_Step !== due) begin
                $display("FAIL hold c=%0d: bcd=%h step=%b, want bcd=%h step=%b",
                         c, o_Bcd, o_Step, to_bcd(exp_cnt), due);
                errors++;
            end
        end
        i_Up = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0004 || o_Step !== 1'b0) begin
                $display("FAIL hold_release c=%0d: bcd=%h step=%b, want bcd=0004 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
    endtask

    task automatic test_wrap_ripple();
        i_Clear = 1'b1; tick(); i_Clear = 1'b0; tick();
        exp_cnt = 0;
        i_Down = 1'b1; tick();
        vectors++;
        if (o_Bcd !== 16'h9999 || o_Step !== 1'b1) begin
            $display("FAIL wrap_down: bcd=%h step=%b, want bcd=9999 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Down = 1'b0; tick();
        i_Up = 1'b1; tick();
        vectors++;
        if (o_Bcd !== 16'h0000 || o_Step !== 1'b1) begin
            $display("FAIL wrap_up: bcd=%h step=%b, want bcd=0000 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Up = 1'b0; tick();
        for (int k = 1; k <= 1000; k++) begin
            i_Up = 1'b1; tick();
            exp_cnt = k;
            vectors++;
            if (o_Bcd !== to_bcd(exp_cnt) || o_Step !== 1'b1) begin
                $display("FAIL ripple_up k=%0d: bcd=%h step=%b, want bcd=%h step=1",
                         k, o_Bcd, o_Step, to_bcd(exp_cnt));
                errors++;
            end
            if (k == 200) begin
                vectors++;
                if (o_Bcd !== 16'h0200) begin
                    $display("FAIL ripple_0199_0200: bcd=%h, want 0200", o_Bcd);
                    errors++;
                end
            end
            i_Up = 1'b0; tick();
            vectors++;
            if (o_Step !== 1'b0) begin
                $display("FAIL ripple_release k=%0d: step=%b, want 0", k, o_Step);
                errors++;
            end
        end
        i_Down = 1'b1; tick();
        exp_cnt = 999;
        vectors++;
        if (o_Bcd !== 16'h0999 || o_Step !== 1'b1) begin
            $display("FAIL ripple_1000_0999: bcd=%h step=%b, want bcd=0999 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Down = 1'b0; tick();
    endtask

    task automatic test_simultaneous();
        i_Up = 1'b1; i_Down = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0999 || o_Step !== 1'b0) begin
                $display("FAIL both_pressed c=%0d: bcd=%h step=%b, want bcd=0999 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
        i_Up = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0999 || o_Step !== 1'b0) begin
                $display("FAIL lock_down_only c=%0d: bcd=%h step=%b, want bcd=0999 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
        i_Down = 1'b0; tick();
        i_Up = 1'b1; tick();
        exp_cnt = 1000;
        vectors++;
        if (o_Bcd !== 16'h1000 || o_Step !== 1'b1) begin
            $display("FAIL after_lock_press: bcd=%h step=%b, want bcd=1000 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Up = 1'b0; tick();
    endtask

    task automatic test_opposite_during_repeat();
        i_Up = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 8) i_Down = 1'b1;
            tick();
            if (c == 0) exp_cnt++;
            vectors++;
            if (o_Bcd !== to_bcd(exp_cnt) || o_Step !== (c == 0)) begin
                $display("FAIL opposite c=%0d: bcd=%h step=%b, want bcd=%h step=%b",
                         c, o_Bcd, o_Step, to_bcd(exp_cnt), (c == 0));
                errors++;
            end
        end
        i_Up = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h1001 || o_Step !== 1'b0) begin
                $display("FAIL opposite_lock c=%0d: bcd=%h step=%b, want bcd=1001 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
        i_Down = 1'b0; tick();
        i_Down = 1'b1; tick();
        exp_cnt = 1000;
        vectors++;
        if (o_Bcd !== 16'h1000 || o_Step !== 1'b1) begin
            $display("FAIL opposite_unlock: bcd=%h step=%b, want bcd=1000 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Down = 1'b0; tick();
    endtask

    task automatic test_clear_and_reset();
        logic due;
        i_Clear = 1'b1; tick(); i_Clear = 1'b0; tick();
        exp_cnt = 0;
        for (int k = 0; k < 41; k++) begin
            i_Up = 1'b1; tick(); exp_cnt++;
            i_Up = 1'b0; tick();
        end
        vectors++;
        if (o_Bcd !== 16'h0041) begin
            $display("FAIL preload_0041: bcd=%h, want 0041", o_Bcd);
            errors++;
        end
        i_Up = 1'b1;
        for (int c = 0; c < 18; c++) begin
            i_Clear = (c >= 7 && c <= 11);
            tick();
            due = (c == 0) || (c == 8) || (c > 8 && ((c - 8) % 4) == 0);
            if (i_Clear) begin
                exp_cnt = 0;
                due     = 1'b0;
            end else if (due) begin
                exp_cnt++;
            end
            vectors++;
            if (o_Bcd !== to_bcd(exp_cnt) || o_Step !== due) begin
                $display("FAIL clear_hold c=%0d: bcd=%h step=%b, want bcd=%h step=%b",
                         c, o_Bcd, o_Step, to_bcd(exp_cnt), due);
                errors++;
            end
        end
        i_Clear = 1'b0;
        vectors++;
        if (o_Bcd !== 16'h0002) begin
            $display("FAIL clear_resume: bcd=%h, want 0002", o_Bcd);
            errors++;
        end
        i_Reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (o_Bcd !== 16'h0000 || o_Step !== 1'b0) begin
                $display("FAIL reset_mid_hold c=%0d: bcd=%h step=%b, want bcd=0000 step=0",
                         c, o_Bcd, o_Step);
                errors++;
            end
        end
        i_Reset = 1'b0;
        tick();
        vectors++;
        if (o_Bcd !== 16'h0001 || o_Step !== 1'b1) begin
            $display("FAIL reset_new_press: bcd=%h step=%b, want bcd=0001 step=1", o_Bcd, o_Step);
            errors++;
        end
        i_Up = 1'b0;
        tick();
        vectors++;
        if (o_Bcd !== 16'h0001 || o_Step !== 1'b0) begin
            $display("FAIL reset_new_release: bcd=%h step=%b, want bcd=0001 step=0", o_Bcd, o_Step);
            errors++;
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        exp_cnt = 0;
        i_Reset = 1'b1;
        i_Up    = 1'b0;
        i_Down  = 1'b0;
        i_Clear = 1'b0;
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_wrap_ripple();
        test_simultaneous();
        test_opposite_during_repeat();
        test_clear_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
